// File: rtl/pkt_filter_queue.sv
// Packet-header FIFO plus type/destination decoder that issues one-cycle unit enables
// and waits for unit_done. Define PKTF_DROPCNT_EN to add the saturating drop_cnt output.
module pkt_filter_queue #(
    parameter int                    WORD_WIDTH = 16,
    parameter int                    TYPE_WIDTH = 3,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID   = {WORD_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  newpkt,
    input  logic [TYPE_WIDTH-1:0] fPktType,
    input  logic [WORD_WIDTH-1:0] destinationID,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic                  unit_done,
    output logic                  pkt_ready,
    output logic                  en_MNI,
    output logic                  en_KCH,
    output logic                  en_QTU,
    output logic                  en_reward,
    output logic                  iAmDestination,
    output logic                  busy,
    output logic                  overflow
`ifdef PKTF_DROPCNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = TYPE_WIDTH + WORD_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ISSUE, S_WAIT} state_t;

    typedef struct packed {
        logic mni;
        logic kch;
        logic qtu;
        logic rew;
        logic iad;
    } dec_t;

    state_t              r_state, w_state_nxt;
    logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    dec_t                r_dec, w_dec;
    logic                w_full, w_empty, w_push, w_pop, w_ovf_drop;
    logic                w_issue, w_issue_any;
    logic [TYPE_WIDTH-1:0] w_head_type;
    logic [WORD_WIDTH-1:0] w_head_dest;
    logic                w_to_me, w_bcast;

    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = (r_state == S_DECODE);
    assign w_push     = newpkt && (!w_full || w_pop);
    assign w_ovf_drop = newpkt && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf_drop) r_overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push && !nrst) r_mem[r_wr_ptr] <= {fPktType, destinationID};
    end

    assign {w_head_type, w_head_dest} = r_mem[r_rd_ptr];
    assign w_to_me = (w_head_dest == myNodeID);
    assign w_bcast = (w_head_dest == BCAST_ID);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_dec = '0;
        case (w_head_type)
            TYPE_WIDTH'(0): begin w_dec.mni = 1'b1; w_dec.rew = 1'b1; end
            TYPE_WIDTH'(1): w_dec.kch = w_to_me || w_bcast;
            TYPE_WIDTH'(2): w_dec.kch = 1'b1;
            TYPE_WIDTH'(3): w_dec.mni = w_to_me;
            TYPE_WIDTH'(4): w_dec.mni = w_to_me || w_bcast;
            TYPE_WIDTH'(5): begin
                w_dec.qtu = 1'b1;
                w_dec.rew = 1'b1;
                w_dec.iad = w_to_me;
            end
            default: w_dec = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst)       r_dec <= '0;
        else if (w_pop) r_dec <= w_dec;
    end

    assign w_issue_any = r_dec.mni || r_dec.kch || r_dec.qtu || r_dec.rew;

    always_ff @(posedge clk) begin
        if (nrst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Enables are gated by reset so a reset landing on the ISSUE cycle emits nothing.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE:   if (!w_empty) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                w_issue     = !nrst;
                w_state_nxt = w_issue_any ? S_WAIT : S_IDLE;
            end
            S_WAIT:   if (unit_done) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign en_MNI         = w_issue && r_dec.mni;
    assign en_KCH         = w_issue && r_dec.kch;
    assign en_QTU         = w_issue && r_dec.qtu;
    assign en_reward      = w_issue && r_dec.rew;
    assign iAmDestination = w_issue && r_dec.iad;
    assign busy           = (r_state != S_IDLE);
    assign overflow       = r_overflow;
    assign pkt_ready      = !w_full;

`ifdef PKTF_DROPCNT_EN
    logic [7:0] r_drop_cnt;
    logic [1:0] w_drop_inc;
    logic [8:0] w_drop_sum;

    // A decode drop and an overflow drop can coincide, so the step can be two.
    assign w_drop_inc = {1'b0, (r_state == S_ISSUE) && !w_issue_any} + {1'b0, w_ovf_drop};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {7'b0, w_drop_inc};

    always_ff @(posedge clk) begin
        if (nrst)               r_drop_cnt <= '0;
        else if (w_drop_sum[8]) r_drop_cnt <= 8'hFF;
        else                    r_drop_cnt <= w_drop_sum[7:0];
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_pkt_filter_queue.sv
// Scoreboard bench for pkt_filter_queue: directed cases, then randomized headers
// checked against a decode-table reference model by a separate monitor process.
module tb_pkt_filter_queue;

    localparam int          DEPTH = 4;
    localparam logic [15:0] ME    = 16'h000C;

    logic        clk = 1'b0;
    logic        nrst, newpkt, unit_done;
    logic [2:0]  fPktType;
    logic [15:0] destinationID, myNodeID;
    logic        pkt_ready, en_MNI, en_KCH, en_QTU, en_reward, iAmDestination, busy, overflow;
`ifdef PKTF_DROPCNT_EN
    logic [7:0]  drop_cnt;
`endif

    logic        resp_done = 1'b0;
    logic        man_done  = 1'b0;
    assign unit_done = resp_done | man_done;

    always #5 clk = ~clk;

    pkt_filter_queue dut (
        .clk            (clk),
        .nrst           (nrst),
        .newpkt         (newpkt),
        .fPktType       (fPktType),
        .destinationID  (destinationID),
        .myNodeID       (myNodeID),
        .unit_done      (unit_done),
        .pkt_ready      (pkt_ready),
        .en_MNI         (en_MNI),
        .en_KCH         (en_KCH),
        .en_QTU         (en_QTU),
        .en_reward      (en_reward),
        .iAmDestination (iAmDestination),
        .busy           (busy),
        .overflow       (overflow)
`ifdef PKTF_DROPCNT_EN
        ,
        .drop_cnt       (drop_cnt)
`endif
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         n_issue = 0;
    int         model_drops = 0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_got;
    bit         resp_en = 1'b1;
    bit         resp_rand = 1'b0;
    int         resp_delay = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: {MNI, KCH, QTU, reward, iAmDestination}; all-zero means dropped.
    function automatic logic [4:0] model(input logic [2:0] t, input logic [15:0] d, input logic [15:0] me);
        logic to_me, bc;
        to_me = (d == me);
        bc    = (d == 16'hFFFF);
        case (t)
            3'd0:    return 5'b10010;
            3'd1:    return (to_me || bc) ? 5'b01000 : 5'b00000;
            3'd2:    return 5'b01000;
            3'd3:    return to_me ? 5'b10000 : 5'b00000;
            3'd4:    return (to_me || bc) ? 5'b10000 : 5'b00000;
            3'd5:    return {4'b0011, to_me};
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic en_any();
        return en_MNI | en_KCH | en_QTU | en_reward | iAmDestination;
    endfunction

    task automatic push_exp(input logic [2:0] t, input logic [15:0] d);
        logic [4:0] e;
        e = model(t, d, ME);
        if (e != 5'b0) exp_q.push_back(e);
        else           model_drops++;
    endtask

    task automatic send(input logic [2:0] t, input logic [15:0] d);
        newpkt        = 1'b1;
        fPktType      = t;
        destinationID = d;
        @(posedge clk); #1;
        newpkt        = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int k, quiet;
        k = 0;
        quiet = 0;
        while (quiet < 3 && k < 300) begin
            @(negedge clk);
            k++;
            if (busy === 1'b0 && exp_q.size() == 0 && unit_done === 1'b0) quiet++;
            else quiet = 0;
        end
        check({name, "_drain"}, 32'(quiet >= 3), 32'd1);
    endtask

    // Monitor: every enable pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        mon_got = {en_MNI, en_KCH, en_QTU, en_reward, iAmDestination};
        if (mon_got != 5'b0) begin
            n_issue++;
            if (exp_q.size() == 0) check("unexpected_issue", 32'(mon_got), 32'h0);
            else                   check("issue_order", 32'(mon_got), 32'(exp_q.pop_front()));
        end
    end

    // Downstream unit model: answers each enable with a unit_done pulse after a delay.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && (en_MNI | en_KCH | en_QTU | en_reward)) begin
                int d;
                d = resp_rand ? int'($urandom_range(0, 3)) : resp_delay;
                @(posedge clk); #1;
                repeat (d) begin @(posedge clk); #1; end
                resp_done = 1'b1;
                @(posedge clk); #1;
                resp_done = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    logic [2:0]  dt [8];
    logic [15:0] dd [8];
    logic [2:0]  bt [6];
    logic [15:0] bd [6];
    logic        rdy [6];
    logic        ovf [6];
    int          snap;

    initial begin
        nrst = 1'b1; newpkt = 1'b0; fPktType = '0; destinationID = '0; myNodeID = ME;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b0;

        @(negedge clk);
        check("rst_enables", 32'(en_any()), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_pkt_ready", 32'(pkt_ready), 32'h1);
`ifdef PKTF_DROPCNT_EN
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif

        // HB: enables two cycles after the accepting edge, busy until unit_done.
        push_exp(3'd0, 16'h0000);
        send(3'd0, 16'h0000);
        @(negedge clk); check("hb_busy_n", 32'(busy), 32'h0);
        @(negedge clk); check("hb_busy_n1", 32'(busy), 32'h1);
                        check("hb_quiet_n1", 32'(en_any()), 32'h0);
        @(negedge clk); check("hb_pulse_n2", 32'({en_MNI, en_reward}), 32'h3);
        @(negedge clk); check("hb_one_cycle", 32'({en_MNI, en_reward}), 32'h0);
                        check("hb_busy_wait", 32'(busy), 32'h1);
        wait_quiet("hb");

        // CHE to another node: dropped, busy for DECODE and ISSUE only.
        push_exp(3'd1, 16'h0008);
        send(3'd1, 16'h0008);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); check("che_drop_busy_n2", 32'(busy), 32'h1);
        @(negedge clk); check("che_drop_idle_n3", 32'(busy), 32'h0);
        wait_quiet("che_drop");

        dt = '{3'd1, 3'd1, 3'd5, 3'd5, 3'd3, 3'd7, 3'd4, 3'd3};
        dd = '{16'h000C, 16'hFFFF, 16'h000C, 16'h000D, 16'hFFFF, 16'h000C, 16'h000C, 16'h000C};
        for (int i = 0; i < 8; i++) begin
            push_exp(dt[i], dd[i]);
            send(dt[i], dd[i]);
            wait_quiet("table");
        end

        // unit_done outside WAIT must be ignored.
        resp_en = 1'b0;
        push_exp(3'd2, 16'h0001);
        send(3'd2, 16'h0001);
        @(posedge clk); #1 man_done = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 man_done = 1'b0;
        repeat (3) @(negedge clk);
        check("early_done_ignored", 32'(busy), 32'h1);
        man_done = 1'b1;
        @(posedge clk); #1 man_done = 1'b0;
        @(negedge clk); check("late_done_releases", 32'(busy), 32'h0);
        resp_en = 1'b1;
        wait_quiet("early_done");

        // Burst of six with unit_done withheld: one in flight plus DEPTH queued, last dropped.
        resp_en = 1'b0;
        snap = n_issue;
        bt = '{3'd0, 3'd2, 3'd5, 3'd4, 3'd2, 3'd0};
        bd = '{16'h0000, 16'h0005, 16'h000C, 16'hFFFF, 16'h0001, 16'h0002};
        for (int i = 0; i < 6; i++) begin
            if (i < DEPTH + 1) push_exp(bt[i], bd[i]);
            else               model_drops++;
            send(bt[i], bd[i]);
            rdy[i] = pkt_ready;
            ovf[i] = overflow;
        end
        check("burst_ready_3", 32'(rdy[3]), 32'h1);
        check("burst_ready_4", 32'(rdy[4]), 32'h0);
        check("burst_ovf_4", 32'(ovf[4]), 32'h0);
        check("burst_ovf_5", 32'(ovf[5]), 32'h1);
        man_done = 1'b1;
        @(posedge clk); #1 man_done = 1'b0;
        resp_en = 1'b1;
        wait_quiet("burst");
        check("burst_issue_count", 32'(n_issue - snap), 32'd5);
        check("overflow_sticky", 32'(overflow), 32'h1);
`ifdef PKTF_DROPCNT_EN
        check("drop_cnt_directed", 32'(drop_cnt), 32'(model_drops));
`endif

        // Reset during WAIT with two headers queued.
        resp_en = 1'b0;
        push_exp(3'd0, 16'h0000);
        send(3'd0, 16'h0000);
        send(3'd2, 16'h0000);
        send(3'd4, 16'h000C);
        @(posedge clk); #1;
        @(negedge clk); check("wait_before_rst", 32'(busy), 32'h1);
        nrst = 1'b1;
        @(posedge clk); #1 nrst = 1'b0;
        model_drops = 0;
        @(negedge clk);
        check("rst_wait_busy", 32'(busy), 32'h0);
        check("rst_wait_ready", 32'(pkt_ready), 32'h1);
        check("rst_wait_ovf_clr", 32'(overflow), 32'h0);
`ifdef PKTF_DROPCNT_EN
        check("rst_wait_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
        repeat (10) @(negedge clk);
        check("rst_wait_flushed", 32'(busy), 32'h0);
        check("rst_wait_exp_empty", 32'(exp_q.size()), 32'h0);
        resp_en = 1'b1;

        // Reset landing on the ISSUE cycle suppresses the pulse.
        send(3'd0, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1 nrst = 1'b1;
        @(negedge clk); check("rst_issue_gated", 32'(en_any()), 32'h0);
        @(posedge clk); #1 nrst = 1'b0;
        @(negedge clk); check("rst_issue_after", 32'(en_any()), 32'h0);
                        check("rst_issue_idle", 32'(busy), 32'h0);
        push_exp(3'd5, 16'h000C);
        send(3'd5, 16'h000C);
        wait_quiet("post_rst");

        // Randomized headers with random unit latency.
        resp_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [2:0]  t;
            logic [15:0] d;
            int          k;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            k = 0;
            while (pkt_ready !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
            check("rand_ready", 32'(pkt_ready), 32'h1);
            t = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       d = ME;
                1:       d = 16'hFFFF;
                2:       d = ME + 16'd1;
                default: d = 16'($urandom);
            endcase
            push_exp(t, d);
            send(t, d);
        end
        wait_quiet("rand");
        check("rand_no_overflow", 32'(overflow), 32'h0);
`ifdef PKTF_DROPCNT_EN
        check("rand_drop_cnt", 32'(drop_cnt), 32'(model_drops));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
